loadable_counter: RTL and testbench



---
 rtl/loadable_counter.sv | 36 +++
 tb/tb_loadable_counter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/loadable_counter.sv
// Purpose : settable up-counter; priority each edge is reset, then load, then increment, then hold.
// Latency : one clock from the sampled inputs to cnt_out. cnt_out is taken directly from the register.
// Backpressure: none. The counter accepts its controls on every cycle and never stalls.
//
// Ports:
//   clk     - single clock; all state changes happen on its rising edge
//   rst     - synchronous reset, active-high; forces the register to zero
//   load    - parallel-load request; loads cnt_in and overrides enab
//   enab    - count enable; increments modulo 2^WIDTH
//   cnt_in  - value captured when load is asserted
//   cnt_out - current counter value, taken straight from the state register
module loadable_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enab,
  input  logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] cnt_out
);

  // The if/else chain sets the priority, so inputs masked by a higher
  // control never reach the register. The WIDTH-bit add drops the carry,
  // which makes the all-ones value wrap to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_out <= '0;
    end else if (load) begin
      cnt_out <= cnt_in;
    end else if (enab) begin
      cnt_out <= cnt_out + WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_loadable_counter.sv
// Bench for loadable_counter at WIDTH=5 and WIDTH=8.
// It applies directed vectors and checks literal expectations.
// A rule-level model also checks both counters on every cycle after the first reset.
module tb_loadable_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load5 = 1'b0, enab5 = 1'b0;
  logic [4:0] in5 = '0;
  logic [4:0] out5;
  logic       load8 = 1'b0, enab8 = 1'b0;
  logic [7:0] in8 = '0;
  logic [7:0] out8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  loadable_counter #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .load(load5), .enab(enab5), .cnt_in(in5), .cnt_out(out5)
  );

  loadable_counter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .load(load8), .enab(enab8), .cnt_in(in8), .cnt_out(out8)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the counter value as a plain integer updated by the priority rules.
  int  m5 = 0, m8 = 0;
  bit  model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m5 = 0;
      m8 = 0;
      model_valid = 1'b1;
    end else begin
      if (load5)      m5 = int'(in5);
      else if (enab5) m5 = (m5 + 1) % 32;
      if (load8)      m8 = int'(in8);
      else if (enab8) m8 = (m8 + 1) % 256;
    end
    #1;
    if (model_valid) begin
      check("model_w5", int'(out5), m5);
      check("model_w8", int'(out8), m8);
    end
  end

  // Drive the 5-bit instance at the falling edge, then check its output 1 time unit after the rising edge.
  task automatic step5(input string name, input logic r, input logic l, input logic e,
                       input logic [4:0] v, input int exp);
    @(negedge clk);
    rst = r; load5 = l; enab5 = e; in5 = v;
    @(posedge clk);
    #1;
    check(name, int'(out5), exp);
  endtask

  task automatic step8(input string name, input logic l, input logic e,
                       input logic [7:0] v, input int exp);
    @(negedge clk);
    rst = 1'b0; load8 = l; enab8 = e; in8 = v;
    @(posedge clk);
    #1;
    check(name, int'(out8), exp);
  endtask

  initial begin
    // Reset has priority over a simultaneous load and enable.
    step5("reset_prio", 1, 1, 1, 5'h1F, 'h00);
    step5("reset_held", 1, 1, 0, 5'h0A, 'h00);
    step5("release_load", 0, 1, 1, 5'h1F, 'h1F);
    step5("wrap_1", 0, 0, 1, 5'h00, 'h00);

    // Back-to-back loads with enable high: load wins every cycle.
    step5("b2b_load_15", 0, 1, 1, 5'h15, 'h15);
    step5("b2b_load_0a", 0, 1, 1, 5'h0A, 'h0A);
    step5("b2b_load_1f", 0, 1, 1, 5'h1F, 'h1F);
    step5("wrap_2", 0, 0, 1, 5'h07, 'h00);

    // Count, then hold.
    step5("load_03", 0, 1, 0, 5'h03, 'h03);
    step5("count_04", 0, 0, 1, 5'h1E, 'h04);
    step5("count_05", 0, 0, 1, 5'h1E, 'h05);
    step5("count_06", 0, 0, 1, 5'h1E, 'h06);
    step5("hold_a", 0, 0, 0, 5'h11, 'h06);
    step5("hold_b", 0, 0, 0, 5'h12, 'h06);

    // Reset in the middle of counting, then release with enable high.
    step5("load_10", 0, 1, 0, 5'h10, 'h10);
    step5("count_11", 0, 0, 1, 5'h00, 'h11);
    step5("count_12", 0, 0, 1, 5'h00, 'h12);
    step5("rst_midcount", 1, 0, 1, 5'h1B, 'h00);
    step5("release_cnt", 0, 0, 1, 5'h1B, 'h01);

    // Inputs masked by reset, using random values, must not leak through.
    for (int i = 0; i < 4; i++) begin
      step5("rst_masked", 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), 'h00);
    end
    step5("post_rst_hold", 0, 0, 0, 5'h09, 'h00);

    // Park the 5-bit instance and exercise the 8-bit one.
    step8("w8_load_ff", 1, 0, 8'hFF, 'hFF);
    step8("w8_wrap", 0, 1, 8'h00, 'h00);
    step8("w8_load_7f", 1, 1, 8'h7F, 'h7F);
    step8("w8_carry", 0, 1, 8'h00, 'h80);
    step8("w8_hold", 0, 0, 8'h55, 'h80);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
